// File: rtl/mcb_bringup_seq.sv
// Spartan-6 DDR3 bring-up sequencer: qualifies BUFPLL lock, holds MCB reset, supervises calibration
// with timeout/retry and runs the self-refresh handshake. Optional build macro: MCB_LOCK_LOSS_RECOVER_EN.
module mcb_bringup_seq #(
    parameter int RST_HOLD_CYC      = 64,
    parameter int LOCK_STABLE_CYC   = 16,
    parameter int CALIB_TIMEOUT_CYC = 65535,
    parameter int MAX_RETRY         = 3,
    parameter int SR_TIMEOUT_CYC    = 1023,
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk0,
    input  logic               sys_rst_i,
    input  logic               pll_lock,
    input  logic               calib_done,
    input  logic               selfrefresh_mode,
    input  logic               sr_req,
    output logic               mcb_rst,
    output logic               selfrefresh_enter,
    output logic               mem_ready,
    output logic               sr_active,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    localparam int LOCK_W = (LOCK_STABLE_CYC > 0) ? $clog2(LOCK_STABLE_CYC + 1) : 1;
    localparam int HOLD_W = (RST_HOLD_CYC > 0) ? $clog2(RST_HOLD_CYC + 1) : 1;
    localparam int CAL_W  = (CALIB_TIMEOUT_CYC > 0) ? $clog2(CALIB_TIMEOUT_CYC + 1) : 1;
    localparam int SR_W   = (SR_TIMEOUT_CYC > 0) ? $clog2(SR_TIMEOUT_CYC + 1) : 1;

    localparam logic [LOCK_W-1:0]  LOCK_LAST = LOCK_W'(LOCK_STABLE_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [CAL_W-1:0]   CAL_LAST  = CAL_W'(CALIB_TIMEOUT_CYC);
    localparam logic [SR_W-1:0]    SR_LAST   = SR_W'(SR_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_CALIB     = 3'd2,
        ST_READY     = 3'd3,
        ST_SR_ENTER  = 3'd4,
        ST_SR        = 3'd5,
        ST_SR_EXIT   = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                lock_meta_q, lock_meta_d;
    logic                lock_sync_q, lock_sync_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CAL_W-1:0]    cal_cnt_q, cal_cnt_d;
    logic [SR_W-1:0]     sr_cnt_q, sr_cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                mcb_rst_q, mcb_rst_d;
    logic                sr_enter_q, sr_enter_d;
    logic                mem_ready_q, mem_ready_d;
    logic                sr_active_q, sr_active_d;
    logic                fail_q, fail_d;
`ifdef MCB_LOCK_LOSS_RECOVER_EN
    logic                lost_q, lost_d;
`endif

    function automatic logic [LOCK_W-1:0] lock_inc(input logic [LOCK_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CAL_W-1:0] cal_inc(input logic [CAL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [SR_W-1:0] sr_inc(input logic [SR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // pll_lock is asynchronous to clk0; two-flop synchronizer
    always_comb begin
        lock_meta_d = pll_lock;
        lock_sync_d = lock_meta_q;
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cal_cnt_d  = cal_cnt_q;
        sr_cnt_d   = sr_cnt_q;
        retry_d    = retry_q;
`ifdef MCB_LOCK_LOSS_RECOVER_EN
        lost_d     = ~lock_sync_q;
`endif

        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (!lock_sync_q)                lock_cnt_d = '0;
                else if (lock_cnt_q == LOCK_LAST) state_d = ST_HOLD;
                else                             lock_cnt_d = lock_inc(lock_cnt_q);
            end
            ST_HOLD: begin
                if (!lock_sync_q)                 state_d = ST_WAIT_LOCK;
                else if (hold_cnt_q == HOLD_LAST) state_d = ST_CALIB;
                else                              hold_cnt_d = hold_inc(hold_cnt_q);
            end
            ST_CALIB: begin
                // calib_done takes priority over a timeout landing on the same cycle
                if (calib_done) begin
                    state_d = ST_READY;
                end else if (cal_cnt_q == CAL_LAST) begin
                    if (retry_q >= RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_HOLD;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cal_cnt_d = cal_inc(cal_cnt_q);
                end
            end
            ST_READY: begin
                if (sr_req) state_d = ST_SR_ENTER;
            end
            ST_SR_ENTER: begin
                if (selfrefresh_mode)          state_d = ST_SR;
                else if (sr_cnt_q == SR_LAST)  state_d = ST_FAIL;
                else                           sr_cnt_d = sr_inc(sr_cnt_q);
            end
            ST_SR: begin
                if (!sr_req) state_d = ST_SR_EXIT;
            end
            ST_SR_EXIT: begin
                // MCB recalibrates after exit, so retry history is kept
                if (!selfrefresh_mode)         state_d = ST_CALIB;
                else if (sr_cnt_q == SR_LAST)  state_d = ST_FAIL;
                else                           sr_cnt_d = sr_inc(sr_cnt_q);
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
        endcase

`ifdef MCB_LOCK_LOSS_RECOVER_EN
        if ((state_q == ST_CALIB || state_q == ST_READY) && !lock_sync_q && lost_q) begin
            state_d = ST_WAIT_LOCK;
            retry_d = '0;
        end
`endif

        if (state_d != state_q) begin
            lock_cnt_d = '0;
            hold_cnt_d = '0;
            cal_cnt_d  = '0;
            sr_cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as state
    always_comb begin
        mcb_rst_d   = (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD) || (state_d == ST_FAIL);
        sr_enter_d  = (state_d == ST_SR_ENTER) || (state_d == ST_SR);
        mem_ready_d = (state_d == ST_READY);
        sr_active_d = (state_d == ST_SR);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk0 or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q     <= ST_WAIT_LOCK;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            cal_cnt_q   <= '0;
            sr_cnt_q    <= '0;
            retry_q     <= '0;
            mcb_rst_q   <= 1'b1;
            sr_enter_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            sr_active_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            cal_cnt_q   <= cal_cnt_d;
            sr_cnt_q    <= sr_cnt_d;
            retry_q     <= retry_d;
            mcb_rst_q   <= mcb_rst_d;
            sr_enter_q  <= sr_enter_d;
            mem_ready_q <= mem_ready_d;
            sr_active_q <= sr_active_d;
            fail_q      <= fail_d;
        end
    end

`ifdef MCB_LOCK_LOSS_RECOVER_EN
    always_ff @(posedge clk0 or negedge sys_rst_i) begin
        if (!sys_rst_i) lost_q <= 1'b0;
        else            lost_q <= lost_d;
    end
`endif

    assign mcb_rst           = mcb_rst_q;
    assign selfrefresh_enter = sr_enter_q;
    assign mem_ready         = mem_ready_q;
    assign sr_active         = sr_active_q;
    assign fail              = fail_q;
    assign retry_cnt         = retry_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_mcb_bringup_seq.sv
// Self-checking bench for mcb_bringup_seq: randomized timing against spec-derived latencies and an output table.
module tb_mcb_bringup_seq;

    localparam int P_HOLD  = 64;
    localparam int P_LOCK  = 16;
    localparam int P_CAL   = 100;
    localparam int P_RETRY = 2;
    localparam int P_SR    = 1023;
    localparam int SYNC    = 2;
    localparam int BRING   = SYNC + P_LOCK + P_HOLD;

    localparam logic [2:0] S_WAIT = 3'd0, S_HOLD = 3'd1, S_CALIB = 3'd2, S_READY = 3'd3;
    localparam logic [2:0] S_SRE  = 3'd4, S_SR   = 3'd5, S_SRX   = 3'd6, S_FAIL  = 3'd7;

    logic       clk0 = 1'b0;
    logic       sys_rst_i = 1'b0;
    logic       pll_lock = 1'b0;
    logic       calib_done = 1'b0;
    logic       selfrefresh_mode = 1'b0;
    logic       sr_req = 1'b0;
    logic       mcb_rst, selfrefresh_enter, mem_ready, sr_active, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;
    logic [4:0] outs;

    int vec  = 0;
    int errs = 0;

    mcb_bringup_seq #(
        .RST_HOLD_CYC     (P_HOLD),
        .LOCK_STABLE_CYC  (P_LOCK),
        .CALIB_TIMEOUT_CYC(P_CAL),
        .MAX_RETRY        (P_RETRY),
        .SR_TIMEOUT_CYC   (P_SR)
    ) dut (
        .clk0             (clk0),
        .sys_rst_i        (sys_rst_i),
        .pll_lock         (pll_lock),
        .calib_done       (calib_done),
        .selfrefresh_mode (selfrefresh_mode),
        .sr_req           (sr_req),
        .mcb_rst          (mcb_rst),
        .selfrefresh_enter(selfrefresh_enter),
        .mem_ready        (mem_ready),
        .sr_active        (sr_active),
        .fail             (fail),
        .retry_cnt        (retry_cnt),
        .state_o          (state_o)
    );

    always #5 clk0 = ~clk0;

    assign outs = {mcb_rst, selfrefresh_enter, mem_ready, sr_active, fail};

    // Required {mcb_rst, selfrefresh_enter, mem_ready, sr_active, fail} per state
    function automatic logic [4:0] outs_for(input logic [2:0] s);
        case (s)
            S_WAIT, S_HOLD: return 5'b10000;
            S_CALIB:        return 5'b00000;
            S_READY:        return 5'b00100;
            S_SRE:          return 5'b01000;
            S_SR:           return 5'b01010;
            S_SRX:          return 5'b00000;
            S_FAIL:         return 5'b10001;
            default:        return 5'bxxxxx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic hold_reset();
        sys_rst_i = 1'b0;
        pll_lock = 1'b0;
        calib_done = 1'b0;
        selfrefresh_mode = 1'b0;
        sr_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_rst();
        pll_lock = 1'b1;
        sys_rst_i = 1'b1;
    endtask

    task automatic wait_rst(input logic v, input int limit, output int n);
        n = 0;
        while (mcb_rst !== v && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_fail(input int limit, output int n);
        n = 0;
        while (fail !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic bring_to_ready(input int w);
        int n;
        hold_reset();
        release_rst();
        wait_rst(1'b0, 4 * BRING, n);
        vec++;
        if (n != BRING || state_o !== S_CALIB) begin
            errs++;
            $display("FAIL bringup_latency: got %0d cycles state %0d, want %0d cycles state %0d", n, state_o, BRING, S_CALIB);
        end
        for (int i = 0; i < w; i++) begin
            sr_req = 1'($urandom_range(0, 1));
            tick();
            vec++;
            if (state_o !== S_CALIB || outs !== outs_for(S_CALIB)) begin
                errs++;
                $display("FAIL calib_wait: cycle %0d got state %0d outs %b, want state %0d outs %b", i, state_o, outs, S_CALIB, outs_for(S_CALIB));
            end
        end
        sr_req = 1'b0;
        calib_done = 1'b1;
        tick();
        calib_done = 1'b0;
        vec++;
        if (state_o !== S_READY || outs !== outs_for(S_READY)) begin
            errs++;
            $display("FAIL calib_to_ready: w=%0d got state %0d outs %b, want state %0d outs %b", w, state_o, outs, S_READY, outs_for(S_READY));
        end
    endtask

    task automatic test_reset();
        hold_reset();
        vec++;
        if (state_o !== S_WAIT || outs !== outs_for(S_WAIT) || retry_cnt !== 2'd0) begin
            errs++;
            $display("FAIL reset_values: got state %0d outs %b retry %0d, want state 0 outs %b retry 0", state_o, outs, retry_cnt, outs_for(S_WAIT));
        end
        release_rst();
        repeat (30) tick();
        vec++;
        if (state_o !== S_HOLD || mcb_rst !== 1'b1) begin
            errs++;
            $display("FAIL reset_hold_reached: got state %0d mcb_rst %b, want state 1 mcb_rst 1", state_o, mcb_rst);
        end
        #2 sys_rst_i = 1'b0;
        #1;
        vec++;
        if (state_o !== S_WAIT || outs !== outs_for(S_WAIT) || retry_cnt !== 2'd0) begin
            errs++;
            $display("FAIL reset_async: got state %0d outs %b, want state 0 outs %b", state_o, outs, outs_for(S_WAIT));
        end
    endtask

    task automatic test_bringup(input int w);
        int k;
        bring_to_ready(w);
        k = $urandom_range(1, 6);
        repeat (k) tick();
        vec++;
        if (state_o !== S_READY || mem_ready !== 1'b1) begin
            errs++;
            $display("FAIL calib_drop_ignored: got state %0d mem_ready %b, want state 3 mem_ready 1", state_o, mem_ready);
        end
    endtask

    task automatic test_lock_glitch(input int g);
        int n;
        hold_reset();
        release_rst();
        repeat (g) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        tick();
        vec++;
        if (state_o !== S_WAIT || mcb_rst !== 1'b1) begin
            errs++;
            $display("FAIL glitch_restart: g=%0d got state %0d mcb_rst %b, want state 0 mcb_rst 1", g, state_o, mcb_rst);
        end
        wait_rst(1'b0, 4 * BRING, n);
        vec++;
        if (n != BRING - 2) begin
            errs++;
            $display("FAIL glitch_latency: g=%0d got %0d cycles, want %0d", g, n, BRING - 2);
        end
    endtask

    task automatic test_calib_retry();
        int n;
        hold_reset();
        release_rst();
        wait_rst(1'b0, 4 * BRING, n);
        vec++;
        if (n != BRING) begin
            errs++;
            $display("FAIL retry_bringup: got %0d, want %0d", n, BRING);
        end
        for (int r = 1; r <= P_RETRY; r++) begin
            wait_rst(1'b1, 4 * P_CAL, n);
            vec++;
            if (n != P_CAL + 1 || retry_cnt !== 2'(r) || state_o !== S_HOLD) begin
                errs++;
                $display("FAIL retry_timeout: r=%0d got %0d cycles retry %0d state %0d, want %0d cycles retry %0d state 1", r, n, retry_cnt, state_o, P_CAL + 1, r);
            end
            wait_rst(1'b0, 4 * P_HOLD, n);
            vec++;
            if (n != P_HOLD || state_o !== S_CALIB) begin
                errs++;
                $display("FAIL retry_hold: r=%0d got %0d cycles state %0d, want %0d cycles state 2", r, n, state_o, P_HOLD);
            end
        end
        wait_fail(4 * P_CAL, n);
        vec++;
        if (n != P_CAL + 1 || state_o !== S_FAIL || outs !== outs_for(S_FAIL) || retry_cnt !== 2'(P_RETRY)) begin
            errs++;
            $display("FAIL retry_exhausted: got %0d cycles state %0d outs %b retry %0d, want %0d cycles state 7 outs %b retry %0d", n, state_o, outs, retry_cnt, P_CAL + 1, outs_for(S_FAIL), P_RETRY);
        end
        for (int i = 0; i < 40; i++) begin
            sr_req = 1'($urandom_range(0, 1));
            calib_done = 1'($urandom_range(0, 1));
            selfrefresh_mode = 1'($urandom_range(0, 1));
            pll_lock = 1'($urandom_range(0, 1));
            tick();
            vec++;
            if (state_o !== S_FAIL || outs !== outs_for(S_FAIL)) begin
                errs++;
                $display("FAIL fail_sticky: cycle %0d got state %0d outs %b, want state 7 outs %b", i, state_o, outs, outs_for(S_FAIL));
            end
        end
    endtask

    task automatic test_self_refresh(input int din, input int dout);
        int n;
        hold_reset();
        release_rst();
        wait_rst(1'b0, 4 * BRING, n);
        wait_rst(1'b1, 4 * P_CAL, n);
        wait_rst(1'b0, 4 * P_HOLD, n);
        calib_done = 1'b1;
        tick();
        calib_done = 1'b0;
        vec++;
        if (state_o !== S_READY || retry_cnt !== 2'd1) begin
            errs++;
            $display("FAIL sr_setup: got state %0d retry %0d, want state 3 retry 1", state_o, retry_cnt);
        end
        sr_req = 1'b1;
        tick();
        vec++;
        if (state_o !== S_SRE || outs !== outs_for(S_SRE)) begin
            errs++;
            $display("FAIL sr_enter: got state %0d outs %b, want state 4 outs %b", state_o, outs, outs_for(S_SRE));
        end
        for (int i = 0; i < din; i++) begin
            sr_req = 1'($urandom_range(0, 1));
            tick();
            vec++;
            if (state_o !== S_SRE) begin
                errs++;
                $display("FAIL sr_enter_wait: cycle %0d got state %0d, want 4", i, state_o);
            end
        end
        sr_req = 1'b1;
        selfrefresh_mode = 1'b1;
        tick();
        vec++;
        if (state_o !== S_SR || outs !== outs_for(S_SR)) begin
            errs++;
            $display("FAIL sr_active: got state %0d outs %b, want state 5 outs %b", state_o, outs, outs_for(S_SR));
        end
        pll_lock = 1'b0;
        repeat (4) tick();
        pll_lock = 1'b1;
        repeat (3) tick();
        vec++;
        if (state_o !== S_SR || sr_active !== 1'b1) begin
            errs++;
            $display("FAIL sr_lock_ignored: got state %0d sr_active %b, want state 5 sr_active 1", state_o, sr_active);
        end
        sr_req = 1'b0;
        tick();
        vec++;
        if (state_o !== S_SRX || outs !== outs_for(S_SRX)) begin
            errs++;
            $display("FAIL sr_exit: got state %0d outs %b, want state 6 outs %b", state_o, outs, outs_for(S_SRX));
        end
        for (int i = 0; i < dout; i++) begin
            sr_req = 1'($urandom_range(0, 1));
            tick();
        end
        sr_req = 1'b0;
        vec++;
        if (state_o !== S_SRX) begin
            errs++;
            $display("FAIL sr_exit_wait: got state %0d, want 6", state_o);
        end
        selfrefresh_mode = 1'b0;
        tick();
        vec++;
        if (state_o !== S_CALIB || mcb_rst !== 1'b0 || retry_cnt !== 2'd1) begin
            errs++;
            $display("FAIL sr_recal: got state %0d mcb_rst %b retry %0d, want state 2 mcb_rst 0 retry 1", state_o, mcb_rst, retry_cnt);
        end
        calib_done = 1'b1;
        tick();
        calib_done = 1'b0;
        vec++;
        if (state_o !== S_READY || mem_ready !== 1'b1) begin
            errs++;
            $display("FAIL sr_ready_again: got state %0d mem_ready %b, want state 3 mem_ready 1", state_o, mem_ready);
        end
    endtask

    task automatic test_sr_timeout(input logic in_exit);
        int n;
        bring_to_ready($urandom_range(0, P_CAL));
        sr_req = 1'b1;
        tick();
        if (in_exit) begin
            selfrefresh_mode = 1'b1;
            tick();
            sr_req = 1'b0;
            tick();
        end
        vec++;
        if (state_o !== (in_exit ? S_SRX : S_SRE)) begin
            errs++;
            $display("FAIL sr_to_setup: exit=%0d got state %0d", in_exit, state_o);
        end
        wait_fail(2 * P_SR, n);
        vec++;
        if (n != P_SR || state_o !== S_FAIL || outs !== outs_for(S_FAIL)) begin
            errs++;
            $display("FAIL sr_timeout: exit=%0d got %0d cycles state %0d outs %b, want %0d cycles state 7 outs %b", in_exit, n, state_o, outs, P_SR, outs_for(S_FAIL));
        end
    endtask

    task automatic test_lock_loss_ready();
        bring_to_ready($urandom_range(0, P_CAL));
        pll_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (state_o !== S_READY || mem_ready !== 1'b1) begin
                errs++;
                $display("FAIL lockloss_early: cycle %0d got state %0d mem_ready %b, want state 3 mem_ready 1", i, state_o, mem_ready);
            end
        end
        pll_lock = 1'b1;
        tick();
`ifdef MCB_LOCK_LOSS_RECOVER_EN
        vec++;
        if (state_o !== S_WAIT || outs !== outs_for(S_WAIT) || retry_cnt !== 2'd0) begin
            errs++;
            $display("FAIL lockloss_recover: got state %0d outs %b retry %0d, want state 0 outs %b retry 0", state_o, outs, retry_cnt, outs_for(S_WAIT));
        end
`else
        for (int i = 0; i < 6; i++) begin
            vec++;
            if (state_o !== S_READY || mem_ready !== 1'b1) begin
                errs++;
                $display("FAIL lockloss_ignored: cycle %0d got state %0d mem_ready %b, want state 3 mem_ready 1", i, state_o, mem_ready);
            end
            tick();
        end
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bringup(P_CAL);
        repeat (3) test_bringup($urandom_range(0, P_CAL - 1));
        test_lock_glitch(12);
        repeat (3) test_lock_glitch($urandom_range(1, 75));
        test_calib_retry();
        test_self_refresh(5, 5);
        test_self_refresh($urandom_range(1, 20), $urandom_range(1, 20));
        test_sr_timeout(1'b0);
        test_sr_timeout(1'b1);
        test_lock_loss_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
